// File: rtl/mem_sched_pkg.sv
// Shared types for the memory port scheduler.
//   owner_e       : which requester owns an in-flight memory request
//   track_entry_t : one tracker slot, owner plus "discard response" flag
//   cnt_w()       : width of a 0..max_out occupancy counter
package mem_sched_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   kill;
    } track_entry_t;

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/mem_owner_tracker.sv
// In-order FIFO recording the owner of every issued memory request.
//   clk, rst         : clock, async active-high reset
//   push_i           : record a newly issued request owned by push_owner_i
//   pop_i            : head response consumed
//   kill_if_i        : mark every valid IF-owned entry (incl. one pushed now) as discard
//   head_o           : head entry (meaningful when !empty_o)
//   empty_o, full_o  : occupancy flags
//   count_o          : number of entries held
module mem_owner_tracker
    import mem_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  owner_e             push_owner_i,
    input  logic               pop_i,
    input  logic               kill_if_i,
    output track_entry_t       head_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [CNT_W-1:0]   count_o
);

    track_entry_t [DEPTH-1:0] ent_q;
    logic [DEPTH-1:0]         vld_q;
    logic [PTR_W-1:0]         rd_q, wr_q;
    logic [CNT_W-1:0]         count_q;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q   <= '0;
            vld_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && wr_q == PTR_W'(i)) begin
                    vld_q[i]       <= 1'b1;
                    ent_q[i].owner <= push_owner_i;
                    ent_q[i].kill  <= kill_if_i && (push_owner_i == OWN_IF);
                end else if (pop_i && rd_q == PTR_W'(i)) begin
                    vld_q[i]      <= 1'b0;
                    ent_q[i].kill <= 1'b0;
                end else if (kill_if_i && vld_q[i] && ent_q[i].owner == OWN_IF) begin
                    ent_q[i].kill <= 1'b1;
                end
            end
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = ent_q[rd_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
//   clk, rst            : clock, async active-high reset
//   if_req_*            : fetch request handshake + address
//   if_resp_*           : fetch response handshake + data
//   if_flush_i          : discard responses of all in-flight fetches
//   ls_req_*            : LSU request handshake + addr/wdata/we/be
//   ls_resp_*           : LSU response handshake + load data
//   mem_req_*           : muxed memory request
//   mem_resp_*          : in-order memory response
//   outstanding_o       : in-flight request count
// LS wins arbitration unless IF has lost STARVE_LIMIT times in a row; a grant
// stalled by mem_req_ready is locked until it fires.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int STARVE_LIMIT    = 4,
    localparam int CNT_W           = cnt_w(MAX_OUTSTANDING),
    localparam int SC_W            = $clog2(STARVE_LIMIT + 1),
    localparam int BE_W            = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid_i,
    output logic                  if_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] if_req_addr_i,
    output logic                  if_resp_valid_o,
    input  logic                  if_resp_ready_i,
    output logic [DATA_WIDTH-1:0] if_resp_data_o,
    input  logic                  if_flush_i,
    input  logic                  ls_req_valid_i,
    output logic                  ls_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata_i,
    input  logic                  ls_req_we_i,
    input  logic [BE_W-1:0]       ls_req_be_i,
    output logic                  ls_resp_valid_o,
    input  logic                  ls_resp_ready_i,
    output logic [DATA_WIDTH-1:0] ls_resp_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
    output logic                  mem_req_we_o,
    output logic [BE_W-1:0]       mem_req_be_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    output logic [CNT_W-1:0]      outstanding_o
);

    logic         lock_q, lock_d;
    owner_e       lock_own_q, lock_own_d;
    logic [SC_W-1:0] starve_q, starve_d;

    owner_e       cand;
    logic         cand_valid, mem_fire, if_fire, resp_pop;
    track_entry_t head;
    logic         trk_empty, trk_full;

    always_comb begin
        if (lock_q)                                                   cand = lock_own_q;
        else if (starve_q == SC_W'(STARVE_LIMIT) && if_req_valid_i)   cand = OWN_IF;
        else if (ls_req_valid_i)                                      cand = OWN_LS;
        else                                                          cand = OWN_IF;
    end

    assign cand_valid = (cand == OWN_LS) ? ls_req_valid_i : if_req_valid_i;
    // rst gate keeps the port quiet while reset is held, even with requesters valid.
    assign mem_req_valid_o = !rst && cand_valid && !trk_full && !(cand == OWN_IF && if_flush_i);
    assign mem_fire        = mem_req_valid_o && mem_req_ready_i;
    assign if_req_ready_o  = mem_fire && (cand == OWN_IF);
    assign ls_req_ready_o  = mem_fire && (cand == OWN_LS);
    assign if_fire         = if_req_ready_o;

    // Fetch requests are always full-word reads.
    assign mem_req_addr_o  = (cand == OWN_LS) ? ls_req_addr_i  : if_req_addr_i;
    assign mem_req_wdata_o = (cand == OWN_LS) ? ls_req_wdata_i : '0;
    assign mem_req_we_o    = (cand == OWN_LS) ? ls_req_we_i    : 1'b0;
    assign mem_req_be_o    = (cand == OWN_LS) ? ls_req_be_i    : '1;

    always_comb begin
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        if (mem_fire) begin
            lock_d = 1'b0;
        end else if (mem_req_valid_o) begin
            lock_d     = 1'b1;
            lock_own_d = cand;
        end
        starve_d = starve_q;
        if (if_fire)                                               starve_d = '0;
        else if (if_req_valid_i && starve_q != SC_W'(STARVE_LIMIT)) starve_d = starve_q + SC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_own_q <= OWN_IF;
            starve_q   <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            starve_q   <= starve_d;
        end
    end

    // Killed (or currently flushed) fetch responses are swallowed here.
    always_comb begin
        if_resp_valid_o  = 1'b0;
        ls_resp_valid_o  = 1'b0;
        mem_resp_ready_o = 1'b0;
        if (!trk_empty) begin
            if (head.owner == OWN_LS) begin
                ls_resp_valid_o  = mem_resp_valid_i;
                mem_resp_ready_o = ls_resp_ready_i;
            end else if (head.kill || if_flush_i) begin
                mem_resp_ready_o = 1'b1;
            end else begin
                if_resp_valid_o  = mem_resp_valid_i;
                mem_resp_ready_o = if_resp_ready_i;
            end
        end
    end

    assign if_resp_data_o = mem_resp_data_i;
    assign ls_resp_data_o = mem_resp_data_i;
    assign resp_pop       = mem_resp_valid_i && mem_resp_ready_o;

    mem_owner_tracker #(.DEPTH(MAX_OUTSTANDING)) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .push_i       (mem_fire),
        .push_owner_i (cand),
        .pop_i        (resp_pop),
        .kill_if_i    (if_flush_i),
        .head_o       (head),
        .empty_o      (trk_empty),
        .full_o       (trk_full),
        .count_o      (outstanding_o)
    );

endmodule

// File: tb/tb_mem_port_scheduler.sv
module tb_mem_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid, if_resp_ready;
    logic [31:0] if_resp_data;
    logic        if_flush;
    logic        ls_req_valid, ls_req_ready;
    logic [31:0] ls_req_addr, ls_req_wdata;
    logic        ls_req_we;
    logic [3:0]  ls_req_be;
    logic        ls_resp_valid, ls_resp_ready;
    logic [31:0] ls_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic [2:0]  outstanding;

    int total = 0;
    int bad   = 0;

    mem_port_scheduler dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_req_addr_i(if_req_addr),
        .if_resp_valid_o(if_resp_valid), .if_resp_ready_i(if_resp_ready), .if_resp_data_o(if_resp_data),
        .if_flush_i(if_flush),
        .ls_req_valid_i(ls_req_valid), .ls_req_ready_o(ls_req_ready), .ls_req_addr_i(ls_req_addr),
        .ls_req_wdata_i(ls_req_wdata), .ls_req_we_i(ls_req_we), .ls_req_be_i(ls_req_be),
        .ls_resp_valid_o(ls_resp_valid), .ls_resp_ready_i(ls_resp_ready), .ls_resp_data_o(ls_resp_data),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
        .mem_req_wdata_o(mem_req_wdata), .mem_req_we_o(mem_req_we), .mem_req_be_o(mem_req_be),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready), .mem_resp_data_i(mem_resp_data),
        .outstanding_o(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        if_req_valid = 0; ls_req_valid = 0; if_flush = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
        if_resp_ready = 1; ls_resp_ready = 1;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1; #1; rst = 0; #1;
    endtask

    bit [5:0] exp_ls_seq = 6'b10_1111;

    initial begin
        quiet();
        rst = 1;
        if_req_addr = 32'h100; ls_req_addr = 32'h200;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_we = 1; ls_req_be = 4'h3;
        mem_resp_data = 32'h0;
        tick(); tick();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_if_resp_valid", if_resp_valid, 0);
        chk("rst_ls_resp_valid", ls_resp_valid, 0);
        rst = 0;

        // Starvation: both always valid, memory drains one response per cycle.
        if_req_valid = 1; ls_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("arb_ls_c%0d", c), ls_req_ready, exp_ls_seq[c]);
            chk($sformatf("arb_if_c%0d", c), if_req_ready, !exp_ls_seq[c]);
            tick();
        end
        if_req_valid = 0; ls_req_valid = 0;
        tick();
        mem_resp_valid = 0; #1;
        chk("arb_drained", outstanding, 0);

        // Grant lock under back-pressure.
        do_reset();
        if_req_valid = 1; if_req_addr = 32'h40; ls_req_addr = 32'h80; #1;
        chk("lock_c1_valid", mem_req_valid, 1);
        chk("lock_c1_addr", mem_req_addr, 32'h40);
        chk("lock_c1_be", mem_req_be, 4'hF);
        chk("lock_c1_wdata", mem_req_wdata, 0);
        tick();
        ls_req_valid = 1; #1;
        chk("lock_c2_addr", mem_req_addr, 32'h40);
        chk("lock_c2_we", mem_req_we, 0);
        chk("lock_c2_ls_rdy", ls_req_ready, 0);
        tick();
        chk("lock_c3_addr", mem_req_addr, 32'h40);
        tick();
        mem_req_ready = 1; #1;
        chk("lock_c4_if_rdy", if_req_ready, 1);
        chk("lock_c4_addr", mem_req_addr, 32'h40);
        tick();
        if_req_valid = 0; #1;
        chk("lock_c5_ls_rdy", ls_req_ready, 1);
        chk("lock_c5_addr", mem_req_addr, 32'h80);
        chk("lock_c5_we", mem_req_we, 1);
        chk("lock_c5_be", mem_req_be, 4'h3);
        chk("lock_c5_wdata", mem_req_wdata, 32'hDEAD_BEEF);
        tick();
        ls_req_valid = 0; mem_req_ready = 0; #1;
        chk("lock_outstanding", outstanding, 2);
        mem_resp_valid = 1; mem_resp_data = 32'h11; #1;
        chk("route_if_valid", if_resp_valid, 1);
        chk("route_if_data", if_resp_data, 32'h11);
        chk("route_if_lsv", ls_resp_valid, 0);
        tick();
        mem_resp_data = 32'h22; #1;
        chk("route_ls_valid", ls_resp_valid, 1);
        chk("route_ls_data", ls_resp_data, 32'h22);
        tick();
        mem_resp_valid = 0; #1;
        chk("route_drained", outstanding, 0);

        // Tracker full.
        do_reset();
        if_req_valid = 1; mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if_req_addr = 32'h1000 + 32'(4 * i);
            tick();
        end
        chk("full_outstanding", outstanding, 4);
        chk("full_mem_valid", mem_req_valid, 0);
        chk("full_if_rdy", if_req_ready, 0);
        tick();
        chk("full_hold_valid", mem_req_valid, 0);
        mem_resp_valid = 1; mem_resp_data = 32'h77; #1;
        chk("full_resp_rdy", mem_resp_ready, 1);
        chk("full_if_resp", if_resp_valid, 1);
        tick();
        mem_resp_valid = 0; #1;
        chk("full_after_pop", outstanding, 3);
        chk("full_reissue", mem_req_valid, 1);

        // Flush: IF, LS, IF in flight, only the LS response is delivered.
        do_reset();
        mem_req_ready = 1;
        if_req_valid = 1; tick();
        if_req_valid = 0; ls_req_valid = 1; tick();
        ls_req_valid = 0; if_req_valid = 1; tick();
        chk("flush_outstanding", outstanding, 3);
        if_flush = 1; #1;
        chk("flush_block_valid", mem_req_valid, 0);
        chk("flush_block_rdy", if_req_ready, 0);
        tick();
        if_flush = 0; if_req_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'hA; #1;
        chk("flush_a_rdy", mem_resp_ready, 1);
        chk("flush_a_ifv", if_resp_valid, 0);
        tick();
        mem_resp_data = 32'hB; #1;
        chk("flush_b_lsv", ls_resp_valid, 1);
        chk("flush_b_data", ls_resp_data, 32'hB);
        tick();
        mem_resp_data = 32'hC; #1;
        chk("flush_c_rdy", mem_resp_ready, 1);
        chk("flush_c_ifv", if_resp_valid, 0);
        chk("flush_c_lsv", ls_resp_valid, 0);
        tick();
        mem_resp_valid = 0; #1;
        chk("flush_drained", outstanding, 0);

        // LS response back-pressure.
        do_reset();
        ls_req_valid = 1; mem_req_ready = 1; tick();
        ls_req_valid = 0; mem_req_ready = 0;
        mem_resp_valid = 1; mem_resp_data = 32'h55; ls_resp_ready = 0; #1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("bp_c%0d_rdy", c), mem_resp_ready, 0);
            chk($sformatf("bp_c%0d_lsv", c), ls_resp_valid, 1);
            tick();
            chk($sformatf("bp_c%0d_out", c), outstanding, 1);
        end
        ls_resp_ready = 1; #1;
        chk("bp_c3_rdy", mem_resp_ready, 1);
        chk("bp_c3_data", ls_resp_data, 32'h55);
        tick();
        mem_resp_valid = 0; #1;
        chk("bp_drained", outstanding, 0);

        // Reset mid-operation with three in flight and an IF lock held.
        do_reset();
        ls_req_valid = 1; mem_req_ready = 1;
        tick(); tick(); tick();
        ls_req_valid = 0; mem_req_ready = 0; if_req_valid = 1; #1;
        chk("mid_outstanding", outstanding, 3);
        chk("mid_if_valid", mem_req_valid, 1);
        tick();
        rst = 1; #1;
        chk("mid_rst_out", outstanding, 0);
        chk("mid_rst_valid", mem_req_valid, 0);
        rst = 0; ls_req_valid = 1; mem_req_ready = 1; #1;
        chk("mid_lock_clr_ls", ls_req_ready, 1);
        chk("mid_lock_clr_if", if_req_ready, 0);
        tick();
        quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
